pipe_stage_reg: RTL and testbench

Parametrised valid/ready pipeline stage register: the general replacement for the fixed IF/ID latch, usable between any two stages of the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with a one-cycle forward latency. An optional two-entry skid buffer makes upstream ready a registered signal. Flush squashes held entries into NOP bubbles, and a saturating counter records downstream back-pressure cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 85 ++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble, and a saturating downstream back-pressure counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = 64'h0000_0000_2000_0000,
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              up_fire;
  logic              dn_fire;

  // With the skid buffer, up_ready comes from state only, so dn_ready never
  // reaches upstream combinationally.
  assign up_ready = (SKID != 0) ? ((state != FULL) && !flush)
                                : (((state == EMPTY) || dn_ready) && !flush);

  assign dn_valid = (state != EMPTY);
  assign dn_data  = dn_valid ? main_data : NOP_VALUE;
  assign up_fire  = up_valid && up_ready;
  assign dn_fire  = dn_valid && dn_ready;

  // Control: occupancy state and back-pressure counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      stall_cnt <= '0;
    end else begin
      if (dn_valid && !dn_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: if (up_fire) state <= ONE;
          ONE: begin
            case ({up_fire, dn_fire})
              2'b01:   state <= EMPTY;
              2'b10:   state <= (SKID != 0) ? FULL : ONE;
              default: state <= ONE;
            endcase
          end
          FULL: if (dn_fire) state <= ONE;
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // Data: payload registers carry no reset; validity lives in state
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: if (up_fire) main_data <= up_data;
      ONE: begin
        if (up_fire && dn_fire)
          main_data <= up_data;
        else if (up_fire)
          skid_data <= up_data;
      end
      FULL: if (dn_fire) main_data <= skid_data;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no-skid, 4-bit counter)
// share stimulus and are compared each cycle against a FIFO reference model.
module tb_pipe_stage_reg;

  localparam logic [63:0] NOP = 64'h0000_0000_2000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, dn_ready;
  logic [63:0] up_data;
  logic        ur [3];
  logic        dv [3];
  logic [63:0] dd [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int checks = 0;
  int errors = 0;

  // reference model: bounded FIFO per instance
  int          m_cap [3] = '{2, 1, 2};
  int          m_max [3] = '{65535, 65535, 15};
  int          m_n   [3];
  int          m_cnt [3];
  logic [63:0] m_d   [3][2];
  bit          fired [3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(1), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(ur[0]),
    .up_data(up_data), .dn_valid(dv[0]), .dn_ready(dn_ready), .dn_data(dd[0]),
    .stall_cnt(sc0));

  pipe_stage_reg #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(0), .CNT_W(16)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(ur[1]),
    .up_data(up_data), .dn_valid(dv[1]), .dn_ready(dn_ready), .dn_data(dd[1]),
    .stall_cnt(sc1));

  pipe_stage_reg #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(ur[2]),
    .up_data(up_data), .dn_valid(dv[2]), .dn_ready(dn_ready), .dn_data(dd[2]),
    .stall_cnt(sc2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int i, input logic dr, input logic fl);
    if (m_cap[i] == 2) return (m_n[i] < 2) && !fl;
    return ((m_n[i] == 0) || dr) && !fl;
  endfunction

  function automatic logic [15:0] dut_cnt(input int i);
    if (i == 0) return sc0;
    if (i == 1) return sc1;
    return {12'd0, sc2};
  endfunction

  // one clock cycle: drive, check at negedge, advance model, take the edge
  task automatic cyc(input logic uv, input logic [63:0] ud, input logic dr,
                     input logic fl, input logic r);
    bit dvm, urm, dfire, ufire;
    up_valid = uv; up_data = ud; dn_ready = dr; flush = fl; rst = r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dvm = (m_n[i] > 0);
      urm = m_ready(i, dr, fl);
      chk($sformatf("up_ready[%0d]", i), {63'd0, ur[i]}, {63'd0, urm});
      chk($sformatf("dn_valid[%0d]", i), {63'd0, dv[i]}, {63'd0, dvm});
      chk($sformatf("dn_data[%0d]", i), dd[i], dvm ? m_d[i][0] : NOP);
      chk($sformatf("stall_cnt[%0d]", i), {48'd0, dut_cnt(i)}, 64'(m_cnt[i]));
      dfire = dvm && dr;
      ufire = uv && urm;
      fired[i] = ufire && !r;
      if (r) begin
        m_n[i] = 0;
        m_cnt[i] = 0;
      end else begin
        if (dvm && !dr && m_cnt[i] < m_max[i]) m_cnt[i]++;
        if (fl) begin
          m_n[i] = 0;
        end else begin
          if (dfire) begin
            m_d[i][0] = m_d[i][1];
            m_n[i]--;
          end
          if (ufire) begin
            m_d[i][m_n[i]] = ud;
            m_n[i]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] v;
    up_valid = 1'b1; up_data = 64'hAAAA; dn_ready = 1'b1; flush = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_cnt[i] = 0; fired[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    chk("rst_dn_valid", {63'd0, dv[0]}, 64'd0);
    chk("rst_dn_data", dd[0], 64'h0000_0000_2000_0000);
    chk("rst_stall_cnt", {48'd0, sc0}, 64'd0);
    chk("rst_up_ready", {63'd0, ur[0]}, 64'd1);
    @(posedge clk);
    #1;

    // streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++) cyc(1'b1, 64'(k), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", {48'd0, sc0}, 64'd0);

    // back-pressure: 0x10 in main, 0x11 in skid, 0x12 waits upstream
    cyc(1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
    chk("bp_stall", {48'd0, sc0}, 64'd3);
    cyc(1'b1, 64'h12, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 64'h12, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // flush while FULL with 0x20/0x21, offering 0x22
    cyc(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h22, 1'b0, 1'b1, 1'b0);
    chk("flush_dn_valid", {63'd0, dv[0]}, 64'd0);
    chk("flush_dn_data", dd[0], NOP);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // no-skid instance with dn_ready toggling, source follows its up_ready
    v = 64'h30;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, v, (k % 2) == 0, 1'b0, 1'b0);
      if (fired[1]) v++;
    end
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // saturation of the 4-bit counter, then reset clears it
    cyc(1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_value", {60'd0, sc2}, 64'd15);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("sat_rst", {60'd0, sc2}, 64'd0);

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 63) == 0));
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
